// File: rtl/fp_pkg.sv
// Shared constants and enumerations for the FP front-end datapath.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned UEXP_W = 9;
    localparam int          BIAS   = 127;

    localparam logic [UEXP_W-1:0] UEXP_INF         = UEXP_W'(128);
    localparam logic [UEXP_W-1:0] UEXP_MIN_NORM    = UEXP_W'(-126);
    localparam logic [UEXP_W-1:0] UEXP_DENORM_NORM = UEXP_W'(-127);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of a packed IEEE-754 value into class, sign,
// initial mantissa (explicit hidden bit) and unbiased exponent.
module fp_classify #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int          BIAS   = 127
) (
    input  logic [EXP_W+FRAC_W:0]  fp_i,
    output logic                   sign_o,
    output fp_pkg::fp_class_e      cls_o,
    output logic [FRAC_W:0]        mant_o,
    output logic [EXP_W:0]         uexp_o
);
    import fp_pkg::*;

    localparam int unsigned UEXP_W = EXP_W + 1;

    // Exponent assigned to Inf/NaN and the starting exponent of a subnormal.
    localparam logic [UEXP_W-1:0] EXP_SPECIAL = UEXP_W'(BIAS + 1);
    localparam logic [UEXP_W-1:0] EXP_MIN     = UEXP_W'(1 - BIAS);

    logic [EXP_W-1:0]  bexp;
    logic [FRAC_W-1:0] frac;

    assign sign_o = fp_i[EXP_W+FRAC_W];
    assign bexp   = fp_i[FRAC_W +: EXP_W];
    assign frac   = fp_i[FRAC_W-1:0];

    // Classify on the biased exponent field, then on the fraction.
    always_comb begin
        cls_o  = NORMAL;
        mant_o = {1'b1, frac};
        uexp_o = UEXP_W'(bexp) - UEXP_W'(BIAS);
        if (bexp == '0) begin
            if (frac == '0) begin
                cls_o  = ZERO;
                mant_o = '0;
                uexp_o = '0;
            end else begin
                cls_o  = DENORM;
                mant_o = {1'b0, frac};
                uexp_o = EXP_MIN;
            end
        end else if (bexp == '1) begin
            uexp_o = EXP_SPECIAL;
            if (frac == '0) begin
                cls_o  = INF;
                mant_o = '0;
            end else begin
                cls_o  = NAN;
                mant_o = {1'b1, frac};
            end
        end
    end

endmodule

// File: rtl/fp_unpacker.sv
// Unpacks an IEEE-754 operand into sign / signed exponent / explicit-one
// mantissa. Subnormals are renormalised one bit per cycle before the
// result is presented; one operand in flight at a time.
module fp_unpacker #(
    parameter int unsigned EXP_W  = fp_pkg::EXP_W,
    parameter int unsigned FRAC_W = fp_pkg::FRAC_W,
    parameter int          BIAS   = fp_pkg::BIAS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRAC_W:0]  fp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign,
    output logic [FRAC_W:0]        uMantissa,
    output logic [EXP_W:0]         uExp,
    output logic                   is_zero,
    output logic                   is_denorm,
    output logic                   is_inf,
    output logic                   is_nan
);
    import fp_pkg::*;

    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned UEXP_W = EXP_W + 1;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [UEXP_W-1:0]   exp_q, exp_d;
    logic                zero_q, zero_d;
    logic                denorm_q, denorm_d;
    logic                inf_q, inf_d;
    logic                nan_q, nan_d;

    logic                cls_sign;
    fp_class_e           cls;
    logic [MANT_W-1:0]   cls_mant;
    logic [UEXP_W-1:0]   cls_exp;

    fp_classify #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .BIAS   (BIAS)
    ) u_classify (
        .fp_i   (fp_in),
        .sign_o (cls_sign),
        .cls_o  (cls),
        .mant_o (cls_mant),
        .uexp_o (cls_exp)
    );

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mant_d    = mant_q;
        exp_d     = exp_q;
        zero_d    = zero_q;
        denorm_d  = denorm_q;
        inf_d     = inf_q;
        nan_d     = nan_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d   = cls_sign;
                    mant_d   = cls_mant;
                    exp_d    = cls_exp;
                    zero_d   = (cls == ZERO);
                    denorm_d = (cls == DENORM);
                    inf_d    = (cls == INF);
                    nan_d    = (cls == NAN);
                    state_d  = (cls == DENORM) ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                // Leave as soon as the shifted value carries the hidden bit.
                mant_d = mant_q << 1;
                exp_d  = exp_q - UEXP_W'(1);
                if (mant_d[MANT_W-1]) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            zero_q   <= zero_d;
            denorm_q <= denorm_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
        end
    end

    assign sign      = sign_q;
    assign uMantissa = mant_q;
    assign uExp      = exp_q;
    assign is_zero   = zero_q;
    assign is_denorm = denorm_q;
    assign is_inf    = inf_q;
    assign is_nan    = nan_q;

endmodule

// File: tb/tb_fp_unpacker.sv
// Directed-vector bench for fp_unpacker with hand-computed expectations.
module tb_fp_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [23:0] uMantissa;
    logic [8:0]  uExp;
    logic        is_zero;
    logic        is_denorm;
    logic        is_inf;
    logic        is_nan;

    int n_checks = 0;
    int n_fail   = 0;

    fp_unpacker #(
        .EXP_W  (8),
        .FRAC_W (23),
        .BIAS   (127)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_in     (fp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .uMantissa (uMantissa),
        .uExp      (uExp),
        .is_zero   (is_zero),
        .is_denorm (is_denorm),
        .is_inf    (is_inf),
        .is_nan    (is_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] fp;
        logic [7:0]  lat;
        logic        sgn;
        logic [23:0] mant;
        logic [8:0]  exp;
        logic [3:0]  flags;   // {zero, denorm, inf, nan}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {is_zero, is_denorm, is_inf, is_nan};
    endfunction

    // Accept one operand from IDLE and wait (bounded) for out_valid.
    task automatic run_op(input logic [31:0] v, output int lat, output int ready_bad);
        fp_in    = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat       = 1;
        ready_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ready_bad++;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat, rbad, unstable;
        logic [23:0] m0;
        logic [8:0]  e0;
        logic [3:0]  f0;
        logic        s0;

        vecs[0] = '{32'h3FC00000, 8'd1,  1'b0, 24'hC00000, 9'h000, 4'b0000};
        vecs[1] = '{32'h00000001, 8'd24, 1'b0, 24'h800000, 9'h16B, 4'b0100};
        vecs[2] = '{32'h80400000, 8'd2,  1'b1, 24'h800000, fp_pkg::UEXP_DENORM_NORM, 4'b0100};
        vecs[3] = '{32'h7F800000, 8'd1,  1'b0, 24'h000000, fp_pkg::UEXP_INF, 4'b0010};
        vecs[4] = '{32'h7FC00001, 8'd1,  1'b0, 24'hC00001, 9'h080, 4'b0001};
        vecs[5] = '{32'h80000000, 8'd1,  1'b1, 24'h000000, 9'h000, 4'b1000};
        vecs[6] = '{32'h7F7FFFFF, 8'd1,  1'b0, 24'hFFFFFF, 9'h07F, 4'b0000};
        vecs[7] = '{32'h00800000, 8'd1,  1'b0, 24'h800000, fp_pkg::UEXP_MIN_NORM, 4'b0000};
        vecs[8] = '{32'h007FFFFF, 8'd2,  1'b0, 24'hFFFFFE, 9'h181, 4'b0100};
        vecs[9] = '{32'hFF800001, 8'd1,  1'b1, 24'h800001, 9'h080, 4'b0001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fp_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.mant",      32'(uMantissa), 32'd0);
        check("rst.exp",       32'(uExp),      32'd0);
        check("rst.flags",     32'(flags()),   32'd0);
        check("rst.sign",      32'(sign),      32'd0);
        rst = 1'b0;

        // Directed vectors: latency, in_ready low while busy, result fields.
        foreach (vecs[i]) begin
            run_op(vecs[i].fp, lat, rbad);
            check($sformatf("v%0d.lat", i),   32'(lat),       32'(vecs[i].lat));
            check($sformatf("v%0d.busy", i),  32'(rbad),      32'd0);
            check($sformatf("v%0d.sign", i),  32'(sign),      32'(vecs[i].sgn));
            check($sformatf("v%0d.mant", i),  32'(uMantissa), 32'(vecs[i].mant));
            check($sformatf("v%0d.exp", i),   32'(uExp),      32'(vecs[i].exp));
            check($sformatf("v%0d.flags", i), 32'(flags()),   32'(vecs[i].flags));
            release_result($sformatf("v%0d", i));
        end

        // Back-pressure: pi held for 5 cycles while in_valid stays high.
        run_op(32'h40490FDB, lat, rbad);
        check("bp.lat",  32'(lat),       32'd1);
        check("bp.mant", 32'(uMantissa), 32'hC90FDB);
        check("bp.exp",  32'(uExp),      32'h001);
        m0 = uMantissa; e0 = uExp; f0 = flags(); s0 = sign;
        unstable = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            fp_in = 32'h00000001 + 32'(c) * 32'h11111111;
            @(posedge clk); #1;
            if (!out_valid || in_ready || uMantissa !== m0 || uExp !== e0 ||
                flags() !== f0 || sign !== s0) unstable++;
        end
        check("bp.stable", 32'(unstable), 32'd0);
        fp_in     = 32'h3F800000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.rel_valid", 32'(out_valid), 32'd0);
        check("bp.rel_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.next_valid", 32'(out_valid), 32'd1);
        check("bp.next_mant",  32'(uMantissa), 32'h800000);
        check("bp.next_exp",   32'(uExp),      32'd0);
        release_result("bp.next");

        // Reset in the middle of a 23-step renormalisation.
        fp_in    = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid.busy", 32'(in_ready | out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.in_ready",  32'(in_ready),  32'd1);
        check("mid.mant",      32'(uMantissa), 32'd0);
        check("mid.exp",       32'(uExp),      32'd0);
        check("mid.flags",     32'(flags()),   32'd0);
        run_op(32'h3F800000, lat, rbad);
        check("post.lat",  32'(lat),       32'd1);
        check("post.mant", 32'(uMantissa), 32'h800000);
        check("post.exp",  32'(uExp),      32'd0);
        release_result("post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
